// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-stage bundle shared by execute, instruct_mem and fetch_sequencer
interface fetch_sequencer_if #(parameter int PC_W = 16);
  logic [PC_W-1:0] imem_pc, imem_instr, redirect_pc, instr, instr_pc, epc;
  logic stall, redirect_valid, irq_req, irq_ret, instr_valid, irq_ack;
  modport master(
    output imem_pc, instr, instr_pc, instr_valid, irq_ack, epc,
    input  imem_instr, stall, redirect_valid, redirect_pc, irq_req, irq_ret
  );
  modport slave(
    input  imem_pc, instr, instr_pc, instr_valid, irq_ack, epc,
    output imem_instr, stall, redirect_valid, redirect_pc, irq_req, irq_ret
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing for a 1-cycle synchronous imem with stall, redirect and interrupts.
// Define FETCH_IRQ_EN to build the interrupt entry/return logic; otherwise irq inputs are ignored.
module fetch_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(1),
  parameter logic [PC_W-1:0] IRQ_VEC  = '0
) (
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tag_q, tag_d;
  logic valid_q, valid_d, take_ret, take_irq, jump;
  // While stalled the memory re-reads the held word so instr stays stable.
  assign bus.imem_pc     = bus.stall && !bus.redirect_valid ? tag_q : pc_q;
  assign bus.instr       = bus.imem_instr;
  assign bus.instr_pc    = tag_q;
  assign bus.instr_valid = valid_q;
  assign jump = bus.redirect_valid || take_ret || take_irq;
  always_comb begin
    pc_d    = bus.redirect_valid ? bus.redirect_pc :
              take_ret ? bus.epc : take_irq ? IRQ_VEC : bus.stall ? pc_q : pc_q + 1'b1;
    tag_d   = jump || bus.stall ? tag_q : bus.imem_pc;
    valid_d = jump ? 1'b0 : bus.stall ? valid_q : 1'b1;
    state_d = jump ? S_FLUSH : bus.stall ? state_q : S_RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      tag_q   <= '0;
      valid_q <= 1'b0;
      state_q <= S_BOOT;
    end else begin
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
`ifdef FETCH_IRQ_EN
  logic busy_q, busy_d, ack_q, ack_d;
  logic [PC_W-1:0] epc_q, epc_d;
  // Entry waits for a consumable word so the interrupted word is never lost.
  assign take_ret = bus.irq_ret && busy_q && !bus.redirect_valid;
  assign take_irq = bus.irq_req && !busy_q && valid_q && !bus.stall && !bus.redirect_valid;
  assign bus.irq_ack = ack_q;
  assign bus.epc     = epc_q;
  always_comb begin
    busy_d = take_ret ? 1'b0 : take_irq ? 1'b1 : busy_q;
    ack_d  = take_irq;
    epc_d  = take_irq ? pc_q : epc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      epc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ack_q  <= ack_d;
      epc_q  <= epc_d;
    end
`else
  assign take_ret    = 1'b0;
  assign take_irq    = 1'b0;
  assign bus.irq_ack = 1'b0;
  assign bus.epc     = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed program-image scenarios plus randomized run against a word-stream model.
module tb_fetch_sequencer;
  localparam int PC_W = 16;
`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fetch_sequencer_if #(.PC_W(PC_W)) bus();
  fetch_sequencer #(.PC_W(PC_W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] image(input logic [15:0] a);
    case (a)
      16'd0: image = 16'h0000;
      16'd1: image = 16'h2456;
      16'd2: image = 16'h6456;
      16'd3: image = 16'h8456;
      16'd4: image = 16'h9456;
      16'd5: image = 16'hC456;
      16'd6: image = 16'hA040;
      16'd7: image = 16'h8030;
      16'd8: image = 16'hF009;
      16'd9: image = 16'hE04E;
      default: image = 16'hF001;
    endcase
  endfunction

  always @(posedge clk) bus.imem_instr <= image(bus.imem_pc);

  // Reference: the next word to deliver and whether the visible word is live.
  logic [15:0] m_pc, m_next, m_epc;
  logic m_valid, m_busy, m_ack;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pc <= 16'h0000; m_next <= 16'h0001; m_epc <= 16'h0000;
      m_valid <= 1'b0; m_busy <= 1'b0; m_ack <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      if (bus.redirect_valid) begin
        m_next <= bus.redirect_pc; m_valid <= 1'b0;
      end else if (IRQ_EN && bus.irq_ret && m_busy) begin
        m_next <= m_epc; m_valid <= 1'b0; m_busy <= 1'b0;
      end else if (IRQ_EN && bus.irq_req && !m_busy && m_valid && !bus.stall) begin
        m_epc <= m_next; m_next <= 16'h0000; m_valid <= 1'b0; m_busy <= 1'b1; m_ack <= 1'b1;
      end else if (!bus.stall) begin
        m_pc <= m_next; m_next <= m_next + 16'd1; m_valid <= 1'b1;
      end
    end

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.irq_req = 1'b0; bus.irq_ret = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 16'h0 || bus.irq_ack !== 1'b0 || bus.epc !== 16'h0) begin
      failures++;
      $display("FAIL reset: valid=%b pc=%h ack=%b epc=%h required 0/0000/0/0000", bus.instr_valid, bus.instr_pc, bus.irq_ack, bus.epc);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(i) || bus.instr !== image(16'(i))) begin
        failures++;
        $display("FAIL boot_seq: valid=%b pc=%h instr=%h required 1/%h/%h", bus.instr_valid, bus.instr_pc, bus.instr, 16'(i), image(16'(i)));
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    checks++;
    if (bus.instr_pc !== 16'd6 || bus.instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_stall: pc=%h valid=%b required 0006/1", bus.instr_pc, bus.instr_valid);
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd6 || bus.instr !== 16'hA040) begin
        failures++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h required 1/0006/A040", bus.instr_valid, bus.instr_pc, bus.instr);
      end
    end
    bus.stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd7 || bus.instr !== 16'h8030) begin
      failures++;
      $display("FAIL stall_release: valid=%b pc=%h instr=%h required 1/0007/8030", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd9;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_bubble: valid=%b required 0", bus.instr_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd9 || bus.instr !== 16'hE04E) begin
      failures++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h required 1/0009/E04E", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFE;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = 16'hFFFE + 16'(i);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp || bus.instr !== image(exp)) begin
        failures++;
        $display("FAIL wrap: valid=%b pc=%h instr=%h required 1/%h/%h", bus.instr_valid, bus.instr_pc, bus.instr, exp, image(exp));
      end
    end
  endtask

`ifdef FETCH_IRQ_EN
  task automatic test_irq();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd2;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.instr_pc !== 16'd3 || bus.instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL irq_setup: pc=%h valid=%b required 0003/1", bus.instr_pc, bus.instr_valid);
    end
    bus.irq_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.irq_ack !== 1'b1 || bus.epc !== 16'd4 || bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL irq_entry: ack=%b epc=%h valid=%b required 1/0004/0", bus.irq_ack, bus.epc, bus.instr_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(i) || bus.instr !== image(16'(i)) || bus.irq_ack !== 1'b0) begin
        failures++;
        $display("FAIL irq_handler: valid=%b pc=%h instr=%h ack=%b required 1/%h/%h/0", bus.instr_valid, bus.instr_pc, bus.instr, bus.irq_ack, 16'(i), image(16'(i)));
      end
    end
    bus.irq_req = 1'b0; bus.irq_ret = 1'b1;
    @(negedge clk);
    bus.irq_ret = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL irq_ret_bubble: valid=%b required 0", bus.instr_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd4 || bus.instr !== image(16'd4)) begin
      failures++;
      $display("FAIL irq_resume: valid=%b pc=%h instr=%h required 1/0004/%h", bus.instr_valid, bus.instr_pc, bus.instr, image(16'd4));
    end
  endtask

  task automatic test_redirect_irq();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd7; bus.irq_req = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.irq_ack !== 1'b0 || bus.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_irq_pri: ack=%b valid=%b required 0/0", bus.irq_ack, bus.instr_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd7 || bus.irq_ack !== 1'b0) begin
      failures++;
      $display("FAIL redir_irq_target: valid=%b pc=%h ack=%b required 1/0007/0", bus.instr_valid, bus.instr_pc, bus.irq_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.irq_ack !== 1'b1 || bus.epc !== 16'd8) begin
      failures++;
      $display("FAIL redir_irq_late: ack=%b epc=%h required 1/0008", bus.irq_ack, bus.epc);
    end
    bus.irq_req = 1'b0; bus.irq_ret = 1'b1;
    @(negedge clk);
    bus.irq_ret = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd8) begin
      failures++;
      $display("FAIL redir_irq_resume: valid=%b pc=%h required 1/0008", bus.instr_valid, bus.instr_pc);
    end
  endtask
`else
  task automatic test_irq_disabled();
    bus.irq_req = 1'b1; bus.irq_ret = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.irq_ack !== 1'b0 || bus.epc !== 16'h0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(i)) begin
        failures++;
        $display("FAIL irq_disabled: ack=%b epc=%h valid=%b pc=%h required 0/0000/1/%h", bus.irq_ack, bus.epc, bus.instr_valid, bus.instr_pc, 16'(i));
      end
    end
    bus.irq_req = 1'b0; bus.irq_ret = 1'b0;
  endtask
`endif

  task automatic test_reset_flush();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd5;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 16'h0 || bus.irq_ack !== 1'b0 || bus.epc !== 16'h0) begin
      failures++;
      $display("FAIL reset_flush: valid=%b pc=%h ack=%b epc=%h required 0/0000/0/0000", bus.instr_valid, bus.instr_pc, bus.irq_ack, bus.epc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'd1 || bus.instr !== 16'h2456) begin
      failures++;
      $display("FAIL reset_restart: valid=%b pc=%h instr=%h required 1/0001/2456", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== m_valid || (m_valid && (bus.instr_pc !== m_pc || bus.instr !== image(m_pc))) ||
          bus.irq_ack !== m_ack || bus.epc !== m_epc) begin
        failures++;
        $display("FAIL random[%0d]: valid=%b pc=%h instr=%h ack=%b epc=%h required %b/%h/%h/%b/%h", i,
                 bus.instr_valid, bus.instr_pc, bus.instr, bus.irq_ack, bus.epc, m_valid, m_pc, image(m_pc), m_ack, m_epc);
      end
      bus.stall = $urandom_range(0, 9) < 3;
      bus.redirect_valid = $urandom_range(0, 9) == 0;
      sel = $urandom_range(0, 3);
      bus.redirect_pc = sel == 0 ? 16'hFFFF : sel == 1 ? 16'hFFFE : sel == 2 ? 16'($urandom_range(0, 9)) : 16'($urandom);
      bus.irq_req = $urandom_range(0, 4) == 0;
      bus.irq_ret = $urandom_range(0, 14) == 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef FETCH_IRQ_EN
    test_irq();
    test_redirect_irq();
`else
    test_irq_disabled();
`endif
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
